// File: rtl/ddr_arb_pkg.sv
// ddr_arb_pkg: shared types and constants for the DDR burst arbiter.
//   arb_state_e - arbiter FSM states
//   CH*_*       - requester indices, also the round-robin priority order
//   is_read()   - true for the two read requesters
package ddr_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StGrant = 2'd1,
        StBurst = 2'd2,
        StDone  = 2'd3
    } arb_state_e;

    localparam logic [1:0] CH0_WR = 2'd0;
    localparam logic [1:0] CH1_WR = 2'd1;
    localparam logic [1:0] CH0_RD = 2'd2;
    localparam logic [1:0] CH1_RD = 2'd3;

    // Read requesters occupy the upper half of the index space.
    function automatic logic is_read(input logic [1:0] idx);
        return idx[1];
    endfunction

endpackage

// File: rtl/ddr_burst_arbiter_rr_arb4.sv
// rr_arb4: combinational 4-way round-robin picker.
//   i_req   [3:0] request vector, bit index = requester index
//   i_ptr   [1:0] highest-priority index for this pick
//   o_grant [3:0] one-hot grant (all zero when no request)
//   o_idx   [1:0] index of the granted requester
//   o_valid       at least one request present
module rr_arb4 (
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_grant,
    output logic [1:0] o_idx,
    output logic       o_valid
);

    logic [1:0] w_cand;

    // Scan from the furthest offset back to the pointer so the nearest
    // requester at/after the pointer is the last (winning) assignment.
    always_comb begin
        o_idx   = i_ptr;
        o_valid = 1'b0;
        w_cand  = i_ptr;
        for (int i = 3; i >= 0; i--) begin
            w_cand = i_ptr + 2'(i);
            if (i_req[w_cand]) begin
                o_idx   = w_cand;
                o_valid = 1'b1;
            end
        end
        o_grant = o_valid ? (4'b0001 << o_idx) : 4'b0000;
    end

endmodule

// File: rtl/ddr_burst_arbiter.sv
// ddr_burst_arbiter: grants one of four burst requesters (ch0 wr, ch1 wr,
// ch0 rd, ch1 rd) round-robin onto a single downstream DDR burst port and
// routes data_req / data_valid / finish back to the winner.
//   i_clk, i_rst_n              phy_clk, async active-low reset
//   i_chN_{wr,rd}_burst_*       requester side (req level, addr, len, data)
//   o_chN_{wr,rd}_burst_*       winner-only data strobes, finish pulses
//   o_mem_*, i_mem_*            downstream burst port
//   i_init_done                 no new grant while low
//   o_timeout_err               sticky burst watchdog flag
// Optional feature: define DDR_ARB_TIMEOUT_EN to enable the burst watchdog
// (TIMEOUT_CYCLES); otherwise o_timeout_err is tied 0 and bursts wait
// indefinitely for i_mem_finish.
module ddr_burst_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 25,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned LEN_W          = 10,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ch0_wr_burst_req,
    input  logic [ADDR_W-1:0] i_ch0_wr_burst_addr,
    input  logic [LEN_W-1:0]  i_ch0_wr_burst_len,
    output logic              o_ch0_wr_burst_data_req,
    input  logic [DATA_W-1:0] i_ch0_wr_burst_data,
    output logic              o_ch0_wr_burst_finish,
    input  logic              i_ch1_wr_burst_req,
    input  logic [ADDR_W-1:0] i_ch1_wr_burst_addr,
    input  logic [LEN_W-1:0]  i_ch1_wr_burst_len,
    output logic              o_ch1_wr_burst_data_req,
    input  logic [DATA_W-1:0] i_ch1_wr_burst_data,
    output logic              o_ch1_wr_burst_finish,
    input  logic              i_ch0_rd_burst_req,
    input  logic [ADDR_W-1:0] i_ch0_rd_burst_addr,
    input  logic [LEN_W-1:0]  i_ch0_rd_burst_len,
    output logic              o_ch0_rd_burst_data_valid,
    output logic [DATA_W-1:0] o_ch0_rd_burst_data,
    output logic              o_ch0_rd_burst_finish,
    input  logic              i_ch1_rd_burst_req,
    input  logic [ADDR_W-1:0] i_ch1_rd_burst_addr,
    input  logic [LEN_W-1:0]  i_ch1_rd_burst_len,
    output logic              o_ch1_rd_burst_data_valid,
    output logic [DATA_W-1:0] o_ch1_rd_burst_data,
    output logic              o_ch1_rd_burst_finish,
    output logic              o_mem_wr_req,
    output logic              o_mem_rd_req,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [LEN_W-1:0]  o_mem_len,
    input  logic              i_mem_wr_data_req,
    output logic [DATA_W-1:0] o_mem_wr_data,
    input  logic              i_mem_rd_data_valid,
    input  logic [DATA_W-1:0] i_mem_rd_data,
    input  logic              i_mem_finish,
    input  logic              i_init_done,
    output logic              o_timeout_err
);

    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    arb_state_e        r_state;
    logic [1:0]        r_ptr;
    logic [1:0]        r_idx;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [LEN_W-1:0]  r_mem_len;
    logic              r_mem_wr_req;
    logic              r_mem_rd_req;
    logic              r_fin_pulse;
    logic              r_timeout_err;

    logic [3:0]        w_req;
    logic [3:0]        w_grant;
    logic [1:0]        w_win_idx;
    logic              w_win_valid;
    logic [ADDR_W-1:0] w_win_addr;
    logic [LEN_W-1:0]  w_win_len;
    logic              w_to_hit;
    logic              w_fin_now;
    logic              w_burst_wr;
    logic              w_burst_rd;
    logic              w_wr_path;

    assign w_req = {i_ch1_rd_burst_req, i_ch0_rd_burst_req,
                    i_ch1_wr_burst_req, i_ch0_wr_burst_req};

    rr_arb4 u_rr_arb4 (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_win_idx),
        .o_valid (w_win_valid)
    );

    always_comb begin
        w_win_addr = '0;
        w_win_len  = '0;
        unique case (1'b1)
            w_grant[0]: begin w_win_addr = i_ch0_wr_burst_addr; w_win_len = i_ch0_wr_burst_len; end
            w_grant[1]: begin w_win_addr = i_ch1_wr_burst_addr; w_win_len = i_ch1_wr_burst_len; end
            w_grant[2]: begin w_win_addr = i_ch0_rd_burst_addr; w_win_len = i_ch0_rd_burst_len; end
            w_grant[3]: begin w_win_addr = i_ch1_rd_burst_addr; w_win_len = i_ch1_rd_burst_len; end
            default: ;
        endcase
    end

`ifdef DDR_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_to_cnt;

    // Counts cycles spent in BURST; zero on the cycle mem req first shows.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_to_cnt <= '0;
        end else if (r_state != StBurst) begin
            r_to_cnt <= '0;
        end else if (!w_to_hit) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    assign w_to_hit = (r_state == StBurst) && (r_to_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign w_to_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= StIdle;
            r_ptr         <= CH0_WR;
            r_idx         <= CH0_WR;
            r_mem_addr    <= '0;
            r_mem_len     <= '0;
            r_mem_wr_req  <= 1'b0;
            r_mem_rd_req  <= 1'b0;
            r_fin_pulse   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_fin_pulse <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_init_done && w_win_valid) begin
                        r_idx      <= w_win_idx;
                        r_mem_addr <= w_win_addr;
                        r_mem_len  <= w_win_len;
                        r_state    <= StGrant;
                    end
                end
                StGrant: begin
                    r_ptr <= r_idx + 2'd1;
                    if (r_mem_len == '0) begin
                        // Zero-length burst: skip the core, finish shows in DONE.
                        r_fin_pulse <= 1'b1;
                        r_state     <= StDone;
                    end else begin
                        r_mem_wr_req <= !is_read(r_idx);
                        r_mem_rd_req <= is_read(r_idx);
                        r_state      <= StBurst;
                    end
                end
                StBurst: begin
                    if (i_mem_finish || w_to_hit) begin
                        r_mem_wr_req <= 1'b0;
                        r_mem_rd_req <= 1'b0;
                        r_state      <= StDone;
`ifdef DDR_ARB_TIMEOUT_EN
                        if (!i_mem_finish) begin
                            r_timeout_err <= 1'b1;
                        end
`endif
                    end
                end
                // One dead cycle lets the finished requester drop its req.
                StDone: r_state <= StIdle;
                default: r_state <= StIdle;
            endcase
        end
    end

    assign w_burst_wr = (r_state == StBurst) && !is_read(r_idx);
    assign w_burst_rd = (r_state == StBurst) && is_read(r_idx);
    assign w_wr_path  = (r_state != StIdle) && !is_read(r_idx);
    assign w_fin_now  = ((r_state == StBurst) && (i_mem_finish || w_to_hit)) || r_fin_pulse;

    assign o_ch0_wr_burst_data_req   = w_burst_wr && (r_idx == CH0_WR) && i_mem_wr_data_req;
    assign o_ch1_wr_burst_data_req   = w_burst_wr && (r_idx == CH1_WR) && i_mem_wr_data_req;
    assign o_ch0_rd_burst_data_valid = w_burst_rd && (r_idx == CH0_RD) && i_mem_rd_data_valid;
    assign o_ch1_rd_burst_data_valid = w_burst_rd && (r_idx == CH1_RD) && i_mem_rd_data_valid;
    assign o_ch0_rd_burst_data       = w_burst_rd ? i_mem_rd_data : '0;
    assign o_ch1_rd_burst_data       = w_burst_rd ? i_mem_rd_data : '0;

    assign o_ch0_wr_burst_finish = w_fin_now && (r_idx == CH0_WR);
    assign o_ch1_wr_burst_finish = w_fin_now && (r_idx == CH1_WR);
    assign o_ch0_rd_burst_finish = w_fin_now && (r_idx == CH0_RD);
    assign o_ch1_rd_burst_finish = w_fin_now && (r_idx == CH1_RD);

    assign o_mem_wr_data = !w_wr_path          ? '0 :
                           (r_idx == CH1_WR)   ? i_ch1_wr_burst_data : i_ch0_wr_burst_data;

    assign o_mem_wr_req  = r_mem_wr_req;
    assign o_mem_rd_req  = r_mem_rd_req;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_len     = r_mem_len;
    assign o_timeout_err = r_timeout_err;

endmodule

// File: tb/tb_ddr_burst_arbiter.sv
// Self-checking bench for ddr_burst_arbiter. A round-robin model (pointer +
// first-requester scan) predicts each winner; random addresses, lengths,
// data and strobe gaps drive the downstream side.
module tb_ddr_burst_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 10;
`ifdef DDR_ARB_TIMEOUT_EN
    localparam int TO_CYC = 512;
`else
    localparam int TO_CYC = 4096;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              rq [4];
    logic [ADDR_W-1:0] ad [4];
    logic [LEN_W-1:0]  ln [4];
    logic [DATA_W-1:0] wd [2];
    logic              mem_wr_data_req = 1'b0;
    logic              mem_rd_data_valid = 1'b0;
    logic [DATA_W-1:0] mem_rd_data = '0;
    logic              mem_finish = 1'b0;
    logic              init_done = 1'b1;

    logic              o_ch0_wr_burst_data_req, o_ch1_wr_burst_data_req;
    logic              o_ch0_wr_burst_finish, o_ch1_wr_burst_finish;
    logic              o_ch0_rd_burst_data_valid, o_ch1_rd_burst_data_valid;
    logic [DATA_W-1:0] o_ch0_rd_burst_data, o_ch1_rd_burst_data;
    logic              o_ch0_rd_burst_finish, o_ch1_rd_burst_finish;
    logic              o_mem_wr_req, o_mem_rd_req, o_timeout_err;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [LEN_W-1:0]  o_mem_len;
    logic [DATA_W-1:0] o_mem_wr_data;

    ddr_burst_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TO_CYC)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ch0_wr_burst_req(rq[0]), .i_ch0_wr_burst_addr(ad[0]), .i_ch0_wr_burst_len(ln[0]),
        .o_ch0_wr_burst_data_req(o_ch0_wr_burst_data_req), .i_ch0_wr_burst_data(wd[0]),
        .o_ch0_wr_burst_finish(o_ch0_wr_burst_finish),
        .i_ch1_wr_burst_req(rq[1]), .i_ch1_wr_burst_addr(ad[1]), .i_ch1_wr_burst_len(ln[1]),
        .o_ch1_wr_burst_data_req(o_ch1_wr_burst_data_req), .i_ch1_wr_burst_data(wd[1]),
        .o_ch1_wr_burst_finish(o_ch1_wr_burst_finish),
        .i_ch0_rd_burst_req(rq[2]), .i_ch0_rd_burst_addr(ad[2]), .i_ch0_rd_burst_len(ln[2]),
        .o_ch0_rd_burst_data_valid(o_ch0_rd_burst_data_valid),
        .o_ch0_rd_burst_data(o_ch0_rd_burst_data), .o_ch0_rd_burst_finish(o_ch0_rd_burst_finish),
        .i_ch1_rd_burst_req(rq[3]), .i_ch1_rd_burst_addr(ad[3]), .i_ch1_rd_burst_len(ln[3]),
        .o_ch1_rd_burst_data_valid(o_ch1_rd_burst_data_valid),
        .o_ch1_rd_burst_data(o_ch1_rd_burst_data), .o_ch1_rd_burst_finish(o_ch1_rd_burst_finish),
        .o_mem_wr_req(o_mem_wr_req), .o_mem_rd_req(o_mem_rd_req),
        .o_mem_addr(o_mem_addr), .o_mem_len(o_mem_len),
        .i_mem_wr_data_req(mem_wr_data_req), .o_mem_wr_data(o_mem_wr_data),
        .i_mem_rd_data_valid(mem_rd_data_valid), .i_mem_rd_data(mem_rd_data),
        .i_mem_finish(mem_finish), .i_init_done(init_done), .o_timeout_err(o_timeout_err)
    );

    // Cumulative per-requester strobe and finish counts.
    int n_dat [4];
    int n_fin [4];
    always @(negedge clk) begin
        if (o_ch0_wr_burst_data_req)   n_dat[0] <= n_dat[0] + 1;
        if (o_ch1_wr_burst_data_req)   n_dat[1] <= n_dat[1] + 1;
        if (o_ch0_rd_burst_data_valid) n_dat[2] <= n_dat[2] + 1;
        if (o_ch1_rd_burst_data_valid) n_dat[3] <= n_dat[3] + 1;
        if (o_ch0_wr_burst_finish)     n_fin[0] <= n_fin[0] + 1;
        if (o_ch1_wr_burst_finish)     n_fin[1] <= n_fin[1] + 1;
        if (o_ch0_rd_burst_finish)     n_fin[2] <= n_fin[2] + 1;
        if (o_ch1_rd_burst_finish)     n_fin[3] <= n_fin[3] + 1;
    end

    int errs = 0;
    int checks = 0;
    int ptr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic fin_of(input int c);
        case (c)
            0: return o_ch0_wr_burst_finish;
            1: return o_ch1_wr_burst_finish;
            2: return o_ch0_rd_burst_finish;
            default: return o_ch1_rd_burst_finish;
        endcase
    endfunction

    function automatic logic any_fin();
        return o_ch0_wr_burst_finish | o_ch1_wr_burst_finish |
               o_ch0_rd_burst_finish | o_ch1_rd_burst_finish;
    endfunction

    // Reference round-robin: first requester at/after the pointer.
    function automatic int pick(input int p);
        for (int i = 0; i < 4; i++) begin
            if (rq[(p + i) % 4]) return (p + i) % 4;
        end
        return -1;
    endfunction

    // Act as the DDR core for one burst by requester c, then check totals.
    task automatic serve(input int c);
        int d0 [4];
        int f0 [4];
        int waited;
        int got;
        bit rd;
        bit stb;
        logic [DATA_W-1:0] rdat;
        rd = (c >= 2);
        for (int i = 0; i < 4; i++) begin
            d0[i] = n_dat[i];
            f0[i] = n_fin[i];
        end
        waited = 0;
        smp();
        while (!(o_mem_wr_req || o_mem_rd_req) && waited < 10) begin
            smp();
            waited++;
        end
        chk("mem_req_seen", 64'(o_mem_wr_req | o_mem_rd_req), 1);
        chk("mem_addr", 64'(o_mem_addr), 64'(ad[c]));
        chk("mem_len", 64'(o_mem_len), 64'(ln[c]));
        chk("mem_dir_wr", 64'(o_mem_wr_req), 64'(!rd));
        got = 0;
        while (got < int'(ln[c])) begin
            tick();
            stb = ($urandom_range(3) != 0);
            wd[0] = $urandom;
            wd[1] = $urandom;
            rdat = $urandom;
            mem_rd_data = rdat;
            if (rd) mem_rd_data_valid = stb;
            else    mem_wr_data_req = stb;
            smp();
            if (stb) begin
                got++;
                if (rd) chk("rd_data", 64'((c == 2) ? o_ch0_rd_burst_data : o_ch1_rd_burst_data),
                            64'(rdat));
                else    chk("wr_data_mux", 64'(o_mem_wr_data), 64'(wd[c]));
            end
        end
        tick();
        mem_wr_data_req = 1'b0;
        mem_rd_data_valid = 1'b0;
        mem_finish = 1'b1;
        smp();
        chk("finish_winner", 64'(fin_of(c)), 1);
        chk("mem_req_held", 64'(o_mem_wr_req | o_mem_rd_req), 1);
        tick();
        mem_finish = 1'b0;
        rq[c] = 1'b0;
        smp();
        chk("mem_req_dropped", 64'(o_mem_wr_req | o_mem_rd_req), 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("data_count_ch%0d", i), 64'(n_dat[i] - d0[i]),
                64'((i == c) ? int'(ln[c]) : 0));
            chk($sformatf("finish_count_ch%0d", i), 64'(n_fin[i] - f0[i]), 64'((i == c) ? 1 : 0));
        end
    endtask

    task automatic grant_next();
        int w;
        w = pick(ptr);
        ptr = (w + 1) % 4;
        serve(w);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 4; i++) begin
            rq[i] = 1'b0;
            ad[i] = '0;
            ln[i] = '0;
        end
        wd[0] = '0;
        wd[1] = '0;

        // Reset state
        tick();
        smp();
        chk("rst_mem_wr_req", 64'(o_mem_wr_req), 0);
        chk("rst_mem_rd_req", 64'(o_mem_rd_req), 0);
        chk("rst_mem_addr", 64'(o_mem_addr), 0);
        chk("rst_mem_wr_data", 64'(o_mem_wr_data), 0);
        chk("rst_timeout_err", 64'(o_timeout_err), 0);
        tick();
        rst_n = 1'b1;

        // Stray mem_finish while idle does nothing
        tick();
        mem_finish = 1'b1;
        smp();
        chk("idle_finish_ignored", 64'(any_fin()), 0);
        tick();
        mem_finish = 1'b0;

        // ch0_wr alone, len=128; mem_wr_req two clocks after req
        ad[0] = ADDR_W'($urandom);
        ln[0] = 10'd128;
        rq[0] = 1'b1;
        tick();
        smp();
        chk("req_to_memreq_1clk", 64'(o_mem_wr_req), 0);
        tick();
        smp();
        chk("req_to_memreq_2clk", 64'(o_mem_wr_req), 1);
        ptr = 1;
        serve(0);

        // All four together, then wrap back to ch0_wr
        for (int i = 0; i < 4; i++) begin
            ad[i] = ADDR_W'(($urandom & 32'hfffff) | (i << 20));
            ln[i] = LEN_W'($urandom_range(8, 1));
            rq[i] = 1'b1;
        end
        repeat (4) grant_next();
        rq[0] = 1'b1;
        rq[3] = 1'b1;
        repeat (2) grant_next();

        // ch1_rd long burst: only ch1 sees data_valid
        tick();
        ad[3] = ADDR_W'($urandom);
        ln[3] = 10'd128;
        rq[3] = 1'b1;
        grant_next();

        // Zero-length ch0_rd
        ad[2] = ADDR_W'($urandom);
        ln[2] = '0;
        rq[2] = 1'b1;
        smp();
        tick();
        smp();
        chk("len0_grant_no_finish", 64'(o_ch0_rd_burst_finish), 0);
        chk("len0_grant_no_memreq", 64'(o_mem_rd_req), 0);
        tick();
        smp();
        chk("len0_finish", 64'(o_ch0_rd_burst_finish), 1);
        chk("len0_done_no_memreq", 64'(o_mem_rd_req), 0);
        tick();
        rq[2] = 1'b0;
        smp();
        chk("len0_finish_single", 64'(o_ch0_rd_burst_finish), 0);
        ptr = 3;

        // init_done low holds off grants
        init_done = 1'b0;
        ad[1] = ADDR_W'($urandom);
        ln[1] = LEN_W'($urandom_range(16, 1));
        rq[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            smp();
            chk("init_low_no_memreq", 64'(o_mem_wr_req | o_mem_rd_req), 0);
        end
        tick();
        init_done = 1'b1;
        tick();
        smp();
        chk("init_high_grant_1clk", 64'(o_mem_wr_req), 0);
        tick();
        smp();
        chk("init_high_grant_2clk", 64'(o_mem_wr_req), 1);
        grant_next();

`ifdef DDR_ARB_TIMEOUT_EN
        // Watchdog: mem_finish never arrives
        tick();
        ad[0] = ADDR_W'($urandom);
        ln[0] = 10'd5;
        rq[0] = 1'b1;
        ptr = 1;
        n = 0;
        smp();
        while (!o_mem_wr_req && n < 10) begin
            smp();
            n++;
        end
        chk("to_memreq_seen", 64'(o_mem_wr_req), 1);
        n = 0;
        while (!o_ch0_wr_burst_finish && n < 2 * TO_CYC) begin
            smp();
            n++;
        end
        chk("to_finish_latency", 64'(n), 64'(TO_CYC));
        tick();
        rq[0] = 1'b0;
        smp();
        chk("to_err_set", 64'(o_timeout_err), 1);
        chk("to_memreq_dropped", 64'(o_mem_wr_req), 0);
`else
        chk("timeout_err_tied", 64'(o_timeout_err), 0);
`endif

        // Async reset mid-burst
        tick();
        ad[1] = ADDR_W'($urandom);
        ln[1] = 10'd50;
        rq[1] = 1'b1;
        n = 0;
        smp();
        while (!o_mem_wr_req && n < 10) begin
            smp();
            n++;
        end
        tick();
        mem_wr_data_req = 1'b1;
        smp();
        chk("pre_rst_data_req", 64'(o_ch1_wr_burst_data_req), 1);
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_wr_req", 64'(o_mem_wr_req), 0);
        chk("rst_mid_data_req", 64'(o_ch1_wr_burst_data_req), 0);
        chk("rst_mid_finish", 64'(any_fin()), 0);
        chk("rst_mid_mem_len", 64'(o_mem_len), 0);
        chk("rst_mid_timeout_err", 64'(o_timeout_err), 0);
        mem_wr_data_req = 1'b0;
        rq[1] = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        ptr = 0;
        // Pointer back at ch0_wr: ch1_wr must beat ch1_rd
        ln[1] = LEN_W'($urandom_range(6, 1));
        ln[3] = LEN_W'($urandom_range(6, 1));
        ad[3] = ADDR_W'($urandom);
        rq[1] = 1'b1;
        rq[3] = 1'b1;
        repeat (2) grant_next();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "time limit");
    end

endmodule
